cog_ctr_seq: RTL and testbench

- Sequencer/arbiter that lets NREQ requesters (cog instruction path, debug port, etc.) safely reprogram one cog_ctr counter instance.
- Each request carries new CTR/FRQ/PHS values plus a write mask.
- The block round-robins between requesters and drives the counter's setctr/setfrq/setphs/data write port one register per cycle.
- When CTR is rewritten, the counter is stopped (CTR=0) before FRQ/PHS change, so no mixed old/new configuration ever accumulates.

---
 rtl/cog_ctr_seq_pkg.sv | 26 ++
 rtl/cog_ctr_rr.sv | 25 ++
 rtl/cog_ctr_seq.sv | 88 ++++++++
 tb/tb_cog_ctr_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cog_ctr_seq_pkg.sv
// cog_ctr_seq_pkg: state encoding, mask bit positions and write-order helper for cog_ctr_seq
package cog_ctr_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STOP = 3'd1,
        S_WFRQ = 3'd2,
        S_WPHS = 3'd3,
        S_WCTR = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    localparam int M_FRQ = 0;
    localparam int M_PHS = 1;
    localparam int M_CTR = 2;

    // Write order is STOP, WFRQ, WPHS, WCTR; each state is skipped when its mask bit is clear.
    function automatic state_t next_state(input state_t s, input logic [2:0] m);
        logic fr, ph, ct;
        fr = m[M_FRQ] && (s inside {S_IDLE, S_STOP});
        ph = m[M_PHS] && (s inside {S_IDLE, S_STOP, S_WFRQ});
        ct = m[M_CTR] && (s inside {S_STOP, S_WFRQ, S_WPHS});
        return s == S_ACK ? S_IDLE :
               (s == S_IDLE && m[M_CTR]) ? S_STOP :
               fr ? S_WFRQ : ph ? S_WPHS : ct ? S_WCTR : S_ACK;
    endfunction
endpackage

// File: rtl/cog_ctr_rr.sv
// cog_ctr_rr: combinational round-robin picker, nearest requester at or above ptr with wrap
module cog_ctr_rr #(
    parameter int NREQ = 2,
    parameter int RRW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [RRW-1:0]  ptr,
    output logic            valid,
    output logic [RRW-1:0]  idx
);
    int best;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        best  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ((i + NREQ - int'(ptr)) % NREQ) < best) begin
                best  = (i + NREQ - int'(ptr)) % NREQ;
                valid = 1'b1;
                idx   = RRW'(i);
            end
        end
    end
endmodule

// File: rtl/cog_ctr_seq.sv
// cog_ctr_seq: round-robin sequencer serialising CTR/FRQ/PHS rewrites into one cog_ctr write port
module cog_ctr_seq
    import cog_ctr_seq_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int RRW  = 3
) (
    input  logic                clk_cog,
    input  logic                nres,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_mask,
    input  logic [32*NREQ-1:0]  req_ctr,
    input  logic [32*NREQ-1:0]  req_frq,
    input  logic [32*NREQ-1:0]  req_phs,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic                setctr,
    output logic                setfrq,
    output logic                setphs,
    output logic [31:0]         data
);
    state_t         state, nxt;
    logic [RRW-1:0] ptr, idx, g_idx;
    logic           g_valid;
    logic [2:0]     mask, g_mask;
    logic [31:0]    ctr, frq, phs, g_ctr, g_frq, g_phs;

    cog_ctr_rr #(.NREQ(NREQ), .RRW(RRW)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .valid (g_valid),
        .idx   (g_idx)
    );

    always_comb begin
        g_mask = '0;
        g_ctr  = '0;
        g_frq  = '0;
        g_phs  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_idx == RRW'(i)) begin
                g_mask = req_mask[i*3 +: 3];
                g_ctr  = req_ctr[i*32 +: 32];
                g_frq  = req_frq[i*32 +: 32];
                g_phs  = req_phs[i*32 +: 32];
            end
        end
    end

    // From IDLE the route is chosen from the winner's live mask; afterwards from the latched one.
    assign nxt = state == S_IDLE ? (g_valid ? next_state(S_IDLE, g_mask) : S_IDLE)
                                 : next_state(state, mask);

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            state <= S_IDLE;
            ptr   <= '0;
            idx   <= '0;
            mask  <= '0;
            ctr   <= '0;
            frq   <= '0;
            phs   <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && g_valid) begin
                idx  <= g_idx;
                mask <= g_mask;
                ctr  <= g_ctr;
                frq  <= g_frq;
                phs  <= g_phs;
            end
            if (state == S_ACK)
                ptr <= idx == RRW'(NREQ - 1) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++)
            ack[i] = state == S_ACK && idx == RRW'(i);
    end

    assign busy   = state != S_IDLE;
    assign setctr = state == S_STOP || state == S_WCTR;
    assign setfrq = state == S_WFRQ;
    assign setphs = state == S_WPHS;
    assign data   = state == S_WFRQ ? frq : state == S_WPHS ? phs : state == S_WCTR ? ctr : '0;
endmodule

// File: tb/tb_cog_ctr_seq.sv
// tb_cog_ctr_seq: scoreboard bench for cog_ctr_seq with directed request vectors
module tb_cog_ctr_seq;
    typedef struct packed {
        logic [2:0]  set;
        logic [1:0]  ack;
        logic [31:0] data;
    } ev_t;

    logic        clk_cog, nres;
    logic [1:0]  req, ack;
    logic [5:0]  req_mask;
    logic [63:0] req_ctr, req_frq, req_phs;
    logic        busy, setctr, setfrq, setphs;
    logic [31:0] data;

    int   tests = 0;
    int   fails = 0;
    ev_t  sbq[$];
    ev_t  e;
    logic [2:0]  set_v;
    logic [31:0] m_ctr = 0, m_frq = 0, m_phs = 0;
    logic [1:0]  raise_pend = '0;
    int          reraise[2] = '{0, 0};
    logic [2:0]  b_set[6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};

    cog_ctr_seq #(.NREQ(2), .RRW(3)) dut (
        .clk_cog  (clk_cog),
        .nres     (nres),
        .req      (req),
        .req_mask (req_mask),
        .req_ctr  (req_ctr),
        .req_frq  (req_frq),
        .req_phs  (req_phs),
        .ack      (ack),
        .busy     (busy),
        .setctr   (setctr),
        .setfrq   (setfrq),
        .setphs   (setphs),
        .data     (data)
    );

    initial begin
        clk_cog = 1'b0;
        forever #5 clk_cog = ~clk_cog;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [1:0] a, input logic [31:0] d);
        sbq.push_back('{set: s, ack: a, data: d});
    endtask

    task automatic set_req(input int r, input logic [2:0] m, input logic [31:0] c,
                           input logic [31:0] f, input logic [31:0] p);
        req_mask[r*3 +: 3]  = m;
        req_ctr[r*32 +: 32] = c;
        req_frq[r*32 +: 32] = f;
        req_phs[r*32 +: 32] = p;
    endtask

    // One cycle; a requester drops req on its ack and optionally re-raises one cycle later.
    task automatic tick();
        @(negedge clk_cog);
        for (int i = 0; i < 2; i++) begin
            if (raise_pend[i]) begin
                req[i] = 1'b1;
                raise_pend[i] = 1'b0;
            end else if (ack[i]) begin
                req[i] = 1'b0;
                if (reraise[i] > 0) begin
                    reraise[i]--;
                    raise_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int n = 0; n < 60; n++) begin
            tick();
            if (sbq.size() == 0 && !busy && req == 2'b00 && raise_pend == 2'b00) return;
        end
        chk({nm, "_timeout_pending"}, sbq.size(), 0);
    endtask

    // Monitor: pops the expected event whenever the DUT writes or acks, and tracks the counter registers.
    initial forever begin
        @(negedge clk_cog);
        set_v = {setctr, setfrq, setphs};
        chk("set_onehot", 32'($countones(set_v) <= 1), 32'd1);
        if (set_v == 3'b000) chk("nowrite_data", data, 32'd0);
        if (set_v != 3'b000 || ack != 2'b00) begin
            if (sbq.size() == 0) begin
                chk("unexpected_event", {27'd0, set_v, ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_set", 32'(set_v), 32'(e.set));
                chk("sb_ack", 32'(ack), 32'(e.ack));
                chk("sb_data", data, e.data);
            end
        end
        if (setctr) m_ctr = data;
        if (setfrq) m_frq = data;
        if (setphs) m_phs = data;
    end

    initial begin
        nres = 1'b0;
        req = 2'b11;
        req_mask = '0;
        req_ctr = '0;
        req_frq = '0;
        req_phs = '0;
        // Reset held with both requesting: everything quiet, then requester 0 wins first.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_set", 32'({setctr, setfrq, setphs}), 32'd0);
            chk("rst_data", data, 32'd0);
        end
        push(3'b000, 2'b01, 32'd0);
        push(3'b000, 2'b10, 32'd0);
        nres = 1'b1;
        wait_idle("reset_release");

        // Full mask on requester 0 with cycle-exact latency; FRQ input changes after grant.
        set_req(0, 3'b111, 32'h1000_0005, 32'h0000_0100, 32'h8000_0000);
        push(3'b100, 2'b00, 32'h0);
        push(3'b010, 2'b00, 32'h100);
        push(3'b001, 2'b00, 32'h8000_0000);
        push(3'b100, 2'b00, 32'h1000_0005);
        push(3'b000, 2'b01, 32'h0);
        req[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) req_frq[31:0] = 32'h0000_FFFF;
            chk("full_set", 32'({setctr, setfrq, setphs}), 32'(b_set[k]));
            chk("full_ack", 32'(ack), k == 4 ? 32'd1 : 32'd0);
            chk("full_busy", 32'(busy), k < 5 ? 32'd1 : 32'd0);
        end
        wait_idle("full");
        chk("model_ctr_full", m_ctr, 32'h1000_0005);

        // Single FRQ write, then an empty mask.
        set_req(1, 3'b001, 32'hDEAD_0000, 32'h55, 32'hBEEF_0000);
        push(3'b010, 2'b00, 32'h55);
        push(3'b000, 2'b10, 32'h0);
        req[1] = 1'b1;
        wait_idle("frq_only");
        set_req(1, 3'b000, 32'h1, 32'h2, 32'h3);
        push(3'b000, 2'b10, 32'h0);
        req[1] = 1'b1;
        tick();
        chk("empty_ack", 32'(ack), 32'd2);
        chk("empty_set", 32'({setctr, setfrq, setphs}), 32'd0);
        wait_idle("empty");
        chk("model_frq_c", m_frq, 32'h55);

        // Both held, each dropping for one cycle after ack: grants alternate 0,1,0,1.
        set_req(0, 3'b001, 32'h0, 32'hA0, 32'h0);
        set_req(1, 3'b010, 32'h0, 32'h0, 32'hB1);
        for (int k = 0; k < 2; k++) begin
            push(3'b010, 2'b00, 32'hA0);
            push(3'b000, 2'b01, 32'h0);
            push(3'b001, 2'b00, 32'hB1);
            push(3'b000, 2'b10, 32'h0);
        end
        reraise = '{1, 1};
        req = 2'b11;
        wait_idle("alternate");

        // Reset lands after FRQ is written: CTR stays stopped, PHS keeps the old value.
        set_req(0, 3'b111, 32'h2, 32'h222, 32'h333);
        push(3'b100, 2'b00, 32'h0);
        push(3'b010, 2'b00, 32'h222);
        req[0] = 1'b1;
        tick();
        tick();
        nres = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_set", 32'({setctr, setfrq, setphs}), 32'd0);
        chk("abort_ctr", m_ctr, 32'h0);
        chk("abort_frq", m_frq, 32'h222);
        chk("abort_phs", m_phs, 32'hB1);
        push(3'b100, 2'b00, 32'h0);
        push(3'b010, 2'b00, 32'h222);
        push(3'b001, 2'b00, 32'h333);
        push(3'b100, 2'b00, 32'h2);
        push(3'b000, 2'b01, 32'h0);
        nres = 1'b1;
        wait_idle("rerequest");
        chk("final_ctr", m_ctr, 32'h2);
        chk("final_frq", m_frq, 32'h222);
        chk("final_phs", m_phs, 32'h333);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
